ex_mem_stage: RTL

Parametrised EX→MEM pipeline stage register with a valid/ready handshake, optional 2-entry skid buffer, flush, x0-write suppression, and a forwarding tap. It sits between the execute unit and the memory-access unit. It carries the writeback triple (destination, write-enable, data) plus the memory-op fields. It replaces the fixed-width, always-advancing EX/MEM latch and adds backpressure and squash support.

---
 rtl/ex_mem_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with valid/ready handshake,
// flush, x0-write suppression and a forwarding tap on the head entry.
// Optional 2-entry skid buffer enabled by defining EX_MEM_SKID_EN;
// without it the stage holds one entry and in_ready is combinational.
module ex_mem_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_wd,
    input  logic              in_wreg,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [OP_W-1:0]   in_mem_op,
    input  logic [DATA_W-1:0] in_mem_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_wd,
    output logic              out_wreg,
    output logic [DATA_W-1:0] out_wdata,
    output logic [OP_W-1:0]   out_mem_op,
    output logic [DATA_W-1:0] out_mem_addr,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_wd,
    output logic [DATA_W-1:0] fwd_wdata,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic [OP_W-1:0]   mem_op;
        logic [DATA_W-1:0] mem_addr;
    } entry_t;

    entry_t in_entry;
    entry_t head_q, head_d;
    logic   head_vld_q, head_vld_d;
    logic   in_fire, out_fire;

`ifdef EX_MEM_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_vld_q, skid_vld_d;
    logic   in_ready_q, in_ready_d;
`endif

    // Build the entry to capture; writes to x0 lose their write enable
    always_comb begin
        in_entry.wd       = in_wd;
        in_entry.wreg     = in_wreg && (in_wd != '0);
        in_entry.wdata    = in_wdata;
        in_entry.mem_op   = in_mem_op;
        in_entry.mem_addr = in_mem_addr;
    end

`ifdef EX_MEM_SKID_EN
    assign in_ready  = in_ready_q;
    assign occupancy = {1'b0, head_vld_q} + {1'b0, skid_vld_q};
`else
    assign in_ready  = !head_vld_q || out_ready;
    assign occupancy = {1'b0, head_vld_q};
`endif

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = head_vld_q && out_ready;

    // Next-state: retire head, promote skid, then place the new entry in
    // the first free slot so arrival order is preserved; flush clears all
    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
`ifdef EX_MEM_SKID_EN
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
`endif
        if (out_fire) begin
            head_vld_d = 1'b0;
        end
`ifdef EX_MEM_SKID_EN
        if (out_fire && skid_vld_q) begin
            head_d     = skid_q;
            head_vld_d = 1'b1;
            skid_vld_d = 1'b0;
        end
`endif
        if (in_fire) begin
            if (!head_vld_d) begin
                head_d     = in_entry;
                head_vld_d = 1'b1;
            end
`ifdef EX_MEM_SKID_EN
            else begin
                skid_d     = in_entry;
                skid_vld_d = 1'b1;
            end
`endif
        end
        // Flush keeps the last head data visible but drops every valid bit
        if (flush) begin
            head_d     = head_q;
            head_vld_d = 1'b0;
`ifdef EX_MEM_SKID_EN
            skid_d     = skid_q;
            skid_vld_d = 1'b0;
`endif
        end
`ifdef EX_MEM_SKID_EN
        in_ready_d = !skid_vld_d;
`endif
    end

    // State registers with synchronous reset dominating everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            head_vld_q <= 1'b0;
`ifdef EX_MEM_SKID_EN
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
`endif
        end else begin
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
`ifdef EX_MEM_SKID_EN
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
`endif
        end
    end

    assign out_valid    = head_vld_q;
    assign out_wd       = head_q.wd;
    assign out_wreg     = head_q.wreg;
    assign out_wdata    = head_q.wdata;
    assign out_mem_op   = head_q.mem_op;
    assign out_mem_addr = head_q.mem_addr;

    // Loads are excluded: their data is not known until MEM completes
    assign fwd_valid = head_vld_q && head_q.wreg && (head_q.mem_op == '0);
    assign fwd_wd    = head_q.wd;
    assign fwd_wdata = head_q.wdata;

endmodule
